// File: rtl/seq_gen_prog.sv
// Programmable output-sequence generator: plays a run-time-loaded word table for 1..DEPTH steps.
// Optional up/down bounce playback is enabled by defining SEQ_GEN_PROG_BOUNCE_EN.
module seq_gen_prog #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop,
    input  logic              start,
    input  logic              adv,
`ifdef SEQ_GEN_PROG_BOUNCE_EN
    input  logic              bounce,
`endif
    input  logic              stop,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    // Storage spans the whole index space so every ptr value is a legal index;
    // slots at or above DEPTH are never written and stay zero.
    localparam int SLOTS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  mem [SLOTS];
    logic [ADDR_W-1:0] ptr, ptr_d, len_q, len_d, ptr_inc, ptr_dec, len_clamped;
    logic              loop_q, loop_d, bounce_q, bounce_d, down_q, down_d;
    logic              bounce_in;
    logic [WIDTH-1:0]  out_d;
    logic              wrap_d, done_d;

`ifdef SEQ_GEN_PROG_BOUNCE_EN
    assign bounce_in = bounce;
`else
    assign bounce_in = 1'b0;
`endif

    assign ptr_inc     = ptr + 1'b1;
    assign ptr_dec     = ptr - 1'b1;
    assign len_clamped = (int'(len) > DEPTH - 1) ? LAST : len;
    assign busy        = (state == RUN);

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        len_d    = len_q;
        loop_d   = loop_q;
        bounce_d = bounce_q;
        down_d   = down_q;
        out_d    = out;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    len_d    = len_clamped;
                    loop_d   = loop;
                    bounce_d = bounce_in;
                    ptr_d    = '0;
                    down_d   = 1'b0;
                    out_d    = mem[0];
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (adv) begin
                    if (!down_q) begin
                        if (ptr < len_q) begin
                            ptr_d = ptr_inc;
                            out_d = mem[ptr_inc];
                        end else if (bounce_q && len_q != '0) begin
                            // Turn around at the top without repeating the endpoint.
                            down_d = 1'b1;
                            ptr_d  = ptr_dec;
                            out_d  = mem[ptr_dec];
                        end else if (loop_q) begin
                            ptr_d  = '0;
                            out_d  = mem[0];
                            wrap_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        if (ptr != '0) begin
                            ptr_d = ptr_dec;
                            out_d = mem[ptr_dec];
                            // A looping bounce restarts upward as soon as it lands on 0.
                            if (ptr_dec == '0 && loop_q) begin
                                down_d = 1'b0;
                                wrap_d = 1'b1;
                            end
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            bounce_q <= 1'b0;
            down_q   <= 1'b0;
            out      <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            bounce_q <= bounce_d;
            down_q   <= down_d;
            out      <= out_d;
            wrap     <= wrap_d;
            done     <= done_d;
            if (state == IDLE && wr_en && int'(wr_addr) < DEPTH) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_seq_gen_prog.sv
// Directed testbench for seq_gen_prog (WIDTH=3, DEPTH=4, ADDR_W=3) with hand-computed expectations.
module tb_seq_gen_prog;

    localparam int WIDTH  = 3;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic [ADDR_W-1:0] len = '0;
    logic              loop = 1'b0;
    logic              start = 1'b0;
    logic              adv = 1'b0;
    logic              stop = 1'b0;
    logic [WIDTH-1:0]  out;
    logic              busy, wrap, done;

    int checkCount = 0;
    int errorCount = 0;

    seq_gen_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .loop    (loop),
        .start   (start),
        .adv     (adv),
`ifdef SEQ_GEN_PROG_BOUNCE_EN
        .bounce  (1'b0),
`endif
        .stop    (stop),
        .out     (out),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, expected);
        end
    endtask

    // Drive control inputs, then let one rising edge happen and settle.
    task automatic applyStimulus(input logic s, input logic p, input logic a);
        start = s;
        stop  = p;
        adv   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [WIDTH-1:0] eOut,
                               input logic eBusy, input logic eWrap, input logic eDone);
        checkOutput({tag, ".out"},  32'(out),  32'(eOut));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, ".wrap"}, 32'(wrap), 32'(eWrap));
        checkOutput({tag, ".done"}, 32'(done), 32'(eDone));
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        applyStimulus(1'b0, 1'b0, 1'b0);
        wr_en   = 1'b0;
    endtask

    task automatic startRun(input logic [ADDR_W-1:0] l, input logic lp);
        len  = l;
        loop = lp;
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        $display("[TB] seq_gen_prog directed test");
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectState("reset", 3'b000, 1'b0, 1'b0, 1'b0);

        writeWord(3'd0, 3'b010);
        writeWord(3'd1, 3'b011);
        writeWord(3'd2, 3'b101);
        writeWord(3'd3, 3'b000);
        writeWord(3'd5, 3'b111);

        // Looping playback over the full table
        startRun(3'd3, 1'b1);
        expectState("loop.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("loop.a1", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("loop.a2", 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("loop.a3", 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("loop.a4", 3'b010, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("loop.a5", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0); expectState("loop.stop", 3'b011, 1'b0, 1'b0, 1'b0);

        // start together with stop in IDLE must not launch
        applyStimulus(1'b1, 1'b1, 1'b0); expectState("startstop", 3'b011, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // One-shot of three words
        startRun(3'd2, 1'b0);
        expectState("once.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("once.a1", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("once.a2", 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("once.end", 3'b101, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("once.idle", 3'b101, 1'b0, 1'b0, 1'b0);

        // Advance gating, abort and restart
        startRun(3'd3, 1'b1);
        expectState("gate.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("gate.a1", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0); expectState("gate.h1", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0); expectState("gate.h2", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("gate.a2", 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1); expectState("gate.stop", 3'b101, 1'b0, 1'b0, 1'b0);
        startRun(3'd3, 1'b1);
        expectState("gate.restart", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Writes during RUN are ignored; len=7 clamps to the last entry
        startRun(3'd7, 1'b0);
        expectState("clamp.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'b111;
        applyStimulus(1'b0, 1'b0, 1'b0);
        wr_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("clamp.a1", 3'b011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("clamp.a2", 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("clamp.a3", 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("clamp.end", 3'b000, 1'b0, 1'b0, 1'b1);

        // Single-entry loop and single-entry one-shot
        startRun(3'd0, 1'b1);
        expectState("len0l.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("len0l.a1", 3'b010, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("len0l.a2", 3'b010, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0); expectState("len0l.h", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        startRun(3'd0, 1'b0);
        expectState("len0o.s0", 3'b010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("len0o.end", 3'b010, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a run clears everything, including the table
        startRun(3'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("rst.pre", 3'b011, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("rst.mid", 3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        startRun(3'd3, 1'b1);
        expectState("rst.s0", 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("rst.a1", 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); expectState("rst.a2", 3'b000, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
